arb_capture_fifo: RTL and testbench

- Sits directly downstream of the two-source arbiter.
- The arbiter has no backpressure, so this block captures every valid beat together with its one-hot source tag into a first-word-fall-through FIFO.
- It presents the beats to the consumer over a valid/ready handshake.
- It flags beats lost to overflow and malformed source tags.

---
 rtl/arb_capture_fifo.sv | 127 ++++++++++++
 tb/tb_arb_capture_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_capture_fifo.sv
// arb_capture_fifo: captures arbiter beats and their one-hot source tag into a FWFT FIFO, flagging drops and bad tags.
// Latency: 1 cycle from t_valid_i to m_valid_o. An empty FIFO does not bypass, so there is no t_* -> m_* path.
// Backpressure: nothing is returned upstream. m_ready_i low holds the head. Beats that arrive while the FIFO is full are dropped.
// Optional per-source and drop counters are enabled with `define ARB_CAPTURE_STATS_EN.
module arb_capture_fifo #(
    parameter int BIT_DEPTH = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_DEPTH-1:0] t_data_i,
    input  logic                 t_valid_i,
    input  logic [1:0]           t_number_i,
    output logic [BIT_DEPTH-1:0] m_data_o,
    output logic [1:0]           m_number_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [CW-1:0]        count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 overflow_o,
    output logic                 bad_tag_o
`ifdef ARB_CAPTURE_STATS_EN
    ,
    output logic [CNT_W-1:0]     acc0_cnt_o,
    output logic [CNT_W-1:0]     acc1_cnt_o,
    output logic [CNT_W-1:0]     drop_cnt_o
`endif
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1 || BIT_DEPTH < 1) begin : g_bad_param
        $error("arb_capture_fifo: DEPTH must be a power of two >= 2, widths >= 1");
    end

    logic [BIT_DEPTH+1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic                 overflow_q;
    logic                 bad_tag_q;

    logic tag_ok;
    logic push;
    logic pop;
    logic drop;
    logic bad_beat;

    assign tag_ok   = (t_number_i == 2'b01) || (t_number_i == 2'b10);
    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign pop      = m_valid_o & m_ready_i;
    // A full FIFO that pops this cycle frees the slot the new beat takes.
    assign push     = t_valid_i & tag_ok & (~full_o | pop);
    assign drop     = t_valid_i & tag_ok & full_o & ~pop;
    assign bad_beat = t_valid_i & ~tag_ok;

    // Storage is intentionally not reset; m_* are meaningless while empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {t_number_i, t_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            bad_tag_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (bad_beat) begin
                bad_tag_q <= 1'b1;
            end
        end
    end

    assign m_valid_o  = ~empty_o;
    assign m_data_o   = mem[rd_ptr][BIT_DEPTH-1:0];
    assign m_number_o = mem[rd_ptr][BIT_DEPTH+1:BIT_DEPTH];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign bad_tag_o  = bad_tag_q;

`ifdef ARB_CAPTURE_STATS_EN
    logic [CNT_W-1:0] acc0_q;
    logic [CNT_W-1:0] acc1_q;
    logic [CNT_W-1:0] drop_q;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc0_q <= '0;
            acc1_q <= '0;
            drop_q <= '0;
        end else begin
            if (push && t_number_i == 2'b01 && acc0_q != '1) begin
                acc0_q <= acc0_q + CNT_W'(1);
            end
            if (push && t_number_i == 2'b10 && acc1_q != '1) begin
                acc1_q <= acc1_q + CNT_W'(1);
            end
            if (drop && drop_q != '1) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign acc0_cnt_o = acc0_q;
    assign acc1_cnt_o = acc1_q;
    assign drop_cnt_o = drop_q;
`endif

endmodule

// File: tb/tb_arb_capture_fifo.sv
// Scoreboard bench for arb_capture_fifo: expected beats are queued when driven and checked when popped.
module tb_arb_capture_fifo;
    localparam int BD = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BD-1:0] t_data_i = '0;
    logic          t_valid_i = 1'b0;
    logic [1:0]    t_number_i = 2'b01;
    logic [BD-1:0] m_data_o;
    logic [1:0]    m_number_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [2:0]    count_o;
    logic          full_o;
    logic          empty_o;
    logic          overflow_o;
    logic          bad_tag_o;
`ifdef ARB_CAPTURE_STATS_EN
    logic [15:0]   acc0_cnt_o;
    logic [15:0]   acc1_cnt_o;
    logic [15:0]   drop_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    logic [BD+1:0] sb[$];

    arb_capture_fifo #(.BIT_DEPTH(BD), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .t_data_i(t_data_i), .t_valid_i(t_valid_i), .t_number_i(t_number_i),
        .m_data_o(m_data_o), .m_number_o(m_number_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .count_o(count_o), .full_o(full_o),
        .empty_o(empty_o), .overflow_o(overflow_o), .bad_tag_o(bad_tag_o)
`ifdef ARB_CAPTURE_STATS_EN
        , .acc0_cnt_o(acc0_cnt_o), .acc1_cnt_o(acc1_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Pop monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && m_valid_o && m_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got tag=%b data=%h, scoreboard empty", m_number_o, m_data_o);
            end else begin
                logic [BD+1:0] exp;
                exp = sb.pop_front();
                if ({m_number_o, m_data_o} !== exp) begin
                    errors++;
                    $display("FAIL pop_order: got tag=%b data=%h, expected tag=%b data=%h",
                             m_number_o, m_data_o, exp[BD+1:BD], exp[BD-1:0]);
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        m_ready_i = 1'b0;
        t_valid_i = 1'b0;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic send(input logic [BD-1:0] d, input logic [1:0] tag, input bit expect_store);
        t_valid_i  = 1'b1;
        t_data_i   = d;
        t_number_i = tag;
        if (expect_store) sb.push_back({tag, d});
        @(posedge clk);
        #1;
        t_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        m_ready_i = 1'b1;
        n = 0;
        while (!empty_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!empty_o || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: empty=%b leftover_expected=%0d, required empty=1 leftover=0",
                     name, empty_o, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
        checks++; if (bad_tag_o !== 1'b0) begin errors++; $display("FAIL reset_bad_tag: got %b want 0", bad_tag_o); end
    endtask

    task automatic test_single();
        m_ready_i = 1'b1;
        send(32'hA5A5_0001, 2'b01, 1'b1);
        checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", m_valid_o); end
        checks++; if (m_data_o !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data: got %h want a5a50001", m_data_o); end
        checks++; if (m_number_o !== 2'b01) begin errors++; $display("FAIL single_tag: got %b want 01", m_number_o); end
        @(posedge clk); #1;
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL single_gone: got %b want 0", m_valid_o); end
    endtask

    task automatic test_fill_overflow();
        m_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(BD'(i), (i % 2 == 1) ? 2'b01 : 2'b10, i <= 4);
            if (i == 4) begin
                checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full_o); end
                checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count_o); end
                checks++; if (m_data_o !== 32'd1) begin errors++; $display("FAIL fill_head_stable: got %h want 1", m_data_o); end
                checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fill_no_ovf_yet: got %b want 0", overflow_o); end
            end
        end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", count_o); end
`ifdef ARB_CAPTURE_STATS_EN
        checks++; if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt_o); end
`endif
        drain("fill");
    endtask

    task automatic test_full_pushpop();
        do_reset(1);
        for (int i = 1; i <= 4; i++) send(BD'(i), (i % 2 == 1) ? 2'b01 : 2'b10, 1'b1);
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL pp_full: got %b want 1", full_o); end
        m_ready_i = 1'b1;
        send(32'd6, 2'b10, 1'b1);
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL pp_count: got %0d want 4", count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b want 0", overflow_o); end
        drain("pushpop");
    endtask

    task automatic test_bad_tag();
        do_reset(1);
        send(32'hDEAD_0000, 2'b00, 1'b0);
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL bad00_empty: got %b want 1", empty_o); end
        checks++; if (bad_tag_o !== 1'b1) begin errors++; $display("FAIL bad00_flag: got %b want 1", bad_tag_o); end
        send(32'hDEAD_0011, 2'b11, 1'b0);
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL bad11_count: got %0d want 0", count_o); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bad_tag_o !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b want 1", bad_tag_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL bad_no_ovf: got %b want 0", overflow_o); end
    endtask

    task automatic test_back_to_back();
        logic [BD-1:0] d;
        logic [1:0]    tag;
        do_reset(1);
        m_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d   = $urandom;
            tag = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            send(d, tag, 1'b1);
            t_valid_i = 1'b0;
            checks++;
            if (m_valid_o !== 1'b1 || count_o !== 3'd1) begin
                errors++;
                $display("FAIL b2b_occupancy[%0d]: got valid=%b count=%0d want valid=1 count=1", i, m_valid_o, count_o);
            end
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        for (int i = 0; i < 3; i++) send(BD'(32'h100 + i), 2'b10, 1'b1);
        send(32'h0, 2'b11, 1'b0);
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL mid_pre_count: got %0d want 3", count_o); end
        do_reset(1);
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", count_o); end
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", m_valid_o); end
        checks++; if (bad_tag_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++; $display("FAIL mid_flags: got bad=%b ovf=%b want 0 0", bad_tag_o, overflow_o);
        end
`ifdef ARB_CAPTURE_STATS_EN
        checks++; if (acc0_cnt_o !== 16'd0 || acc1_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin
            errors++; $display("FAIL mid_stats_clear: got %0d %0d %0d want 0 0 0", acc0_cnt_o, acc1_cnt_o, drop_cnt_o);
        end
`endif
        m_ready_i = 1'b1;
        send(32'd7, 2'b01, 1'b1);
        drain("mid");
`ifdef ARB_CAPTURE_STATS_EN
        checks++; if (acc0_cnt_o !== 16'd1 || acc1_cnt_o !== 16'd0) begin
            errors++; $display("FAIL mid_stats_track: got acc0=%0d acc1=%0d want 1 0", acc0_cnt_o, acc1_cnt_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_pushpop();
        test_bad_tag();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
